// File: rtl/fetch_controller_pkg.sv
// Shared types for the fetch path: FSM states, PC increment and the prefetch entry layout.
// Entry widths are fixed here; the controller's ADDR_W/DATA_W defaults track them.
package fetch_pkg;

   localparam int ENTRY_ADDR_W = 32;
   localparam int ENTRY_DATA_W = 32;
   localparam int PC_STEP      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0] pc;
      logic [ENTRY_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_fifo.sv
// Prefetch FIFO of fetch entries: push/pop/flush, registered pointers. A push is visible on
// rdata_o one cycle later (no bypass); the caller gates push on space, and flush wins over both.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  fetch_entry_t               wdata_i,
   output fetch_entry_t               rdata_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t   mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their natural width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push_i && !pop_i)      count_q <= count_q + CW'(1);
         else if (pop_i && !push_i) count_q <= count_q - CW'(1);
      end
   end

   assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, captures imem words into the prefetch FIFO, hands them to decode.
// Fetch-to-decode latency 1 cycle; stalls on FIFO full unless decode pops the same cycle.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W     = ENTRY_ADDR_W,
   parameter int                 DATA_W     = ENTRY_DATA_W,
   parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
   parameter int                 FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0]  HALT_INSN  = '1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           fetch_en,
   output logic [ADDR_W-1:0]              imem_addr,
   input  logic [DATA_W-1:0]              imem_instr,
   input  logic                           redirect_valid,
   input  logic [ADDR_W-1:0]              redirect_pc,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ADDR_W-1:0]              out_pc,
   output logic [DATA_W-1:0]              out_instr,
   output logic                           halted,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                push, pop, has_space;
   fetch_entry_t        wr_entry, head;

   assign has_space = (fifo_count < CW'(FIFO_DEPTH));
   assign pop       = out_valid && out_ready;
   assign push      = (state_q == FETCH) && fetch_en && !redirect_valid && (has_space || pop);

   always_comb begin
      wr_entry       = '0;
      wr_entry.pc    = pc_q;
      wr_entry.instr = imem_instr;
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .wdata_i (wr_entry),
      .rdata_o (head),
      .count_o (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Redirect takes priority over every other transition, including leaving HALTED.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = fetch_en ? FETCH : IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (fetch_en) state_d = FETCH;
            FETCH: begin
               if (!fetch_en)                           state_d = IDLE;
               else if (push && imem_instr == HALT_INSN) state_d = HALTED;
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      imem_addr = pc_q;
      out_valid = (fifo_count != '0) && !redirect_valid;
      halted    = (state_q == HALTED);
      out_pc    = head.pc;
      out_instr = head.instr;
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (push)      pc_d = pc_q + ADDR_W'(PC_STEP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_controller;

   localparam int          DEPTH = 4;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        halted;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   logic [31:0] imem [64];
   assign imem_instr = imem[imem_addr[7:2]];

   fetch_controller dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .halted         (halted),
      .fifo_count     (fifo_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of fetched entries plus the fetch PC and a run state.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;
   ent_t        q[$];
   logic [31:0] m_pc;
   int          m_st;   // 0 idle, 1 fetching, 2 halted

   task automatic m_reset();
      q.delete();
      m_pc = 32'h0;
      m_st = 0;
   endtask

   task automatic m_step();
      bit          v, pop, push;
      logic [31:0] w;
      ent_t        e;
      v   = (q.size() != 0) && !redirect_valid;
      pop = v && out_ready;
      if (redirect_valid) begin
         q.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
         m_st = fetch_en ? 1 : 0;
      end else begin
         w    = imem[m_pc[7:2]];
         push = (m_st == 1) && fetch_en && ((q.size() < DEPTH) || pop);
         if (pop) void'(q.pop_front());
         if (push) begin
            e.pc  = m_pc;
            e.ins = w;
            q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
         if (m_st == 0 && fetch_en)                m_st = 1;
         else if (m_st == 1 && !fetch_en)          m_st = 0;
         else if (m_st == 1 && push && w == HALT)  m_st = 2;
      end
   endtask

   function automatic logic [31:0] m_head_pc();
      return (q.size() != 0) ? q[0].pc : 32'h0;
   endfunction

   function automatic logic [31:0] m_head_ins();
      return (q.size() != 0) ? q[0].ins : 32'h0;
   endfunction

   task automatic drive(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
      fetch_en       = fe;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (fifo_count !== 3'd0)  begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      checks++; if (halted !== 1'b0)      begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      checks++; if (imem_addr !== 32'h0)  begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0)
         begin errors++; $display("FAIL reset_head: got pc %h instr %h want 0/0", out_pc, out_instr); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checks++; if (imem_addr !== 32'h0 || fifo_count !== 3'd0)
         begin errors++; $display("FAIL idle_hold: got addr %h count %0d want 0/0", imem_addr, fifo_count); end
   endtask

   task automatic test_stream();
      logic [31:0] ea, ep;
      do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         ea = (k < 2) ? 32'h0 : 32'((k - 1) * 4);
         ep = (k < 2) ? 32'h0 : 32'((k - 2) * 4);
         checks++; if (imem_addr !== ea)
            begin errors++; $display("FAIL stream_addr k=%0d: got %h want %h", k, imem_addr, ea); end
         checks++; if (out_valid !== (k >= 2) || out_pc !== ep)
            begin errors++; $display("FAIL stream_out k=%0d: got v%b pc %h want v%b pc %h", k, out_valid, out_pc, k >= 2, ep); end
         if (k >= 2) begin
            checks++; if (out_instr !== imem[ep[7:2]])
               begin errors++; $display("FAIL stream_instr k=%0d: got %h want %h", k, out_instr, imem[ep[7:2]]); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      int          n, pops;
      logic [31:0] nxt;
      do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         n = (k < 2) ? 0 : ((k - 1 > 4) ? 4 : k - 1);
         checks++; if (fifo_count !== 3'(n) || imem_addr !== 32'(n * 4))
            begin errors++; $display("FAIL stall_fill k=%0d: got count %0d addr %h want %0d %h", k, fifo_count, imem_addr, n, n * 4); end
         tick();
      end
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      nxt  = 32'h0;
      pops = 0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) begin
            checks++; if (out_pc !== nxt || out_instr !== imem[nxt[7:2]])
               begin errors++; $display("FAIL stall_order: got pc %h instr %h want %h %h", out_pc, out_instr, nxt, imem[nxt[7:2]]); end
            nxt = nxt + 32'd4;
            pops++;
         end
         tick();
      end
      checks++; if (pops != 20) begin errors++; $display("FAIL stall_pops: got %0d want 20", pops); end
   endtask

   task automatic test_redirect();
      do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (4) tick();
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL redir_pre: got count %0d want 3", fifo_count); end
      drive(1'b1, 1'b1, 32'h23, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", out_valid); end
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (fifo_count !== 3'd0 || imem_addr !== 32'h20 || out_valid !== 1'b0)
         begin errors++; $display("FAIL redir_flush: got count %0d addr %h v%b want 0 20 0", fifo_count, imem_addr, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20)
         begin errors++; $display("FAIL redir_first: got v%b pc %h want 1 20", out_valid, out_pc); end
      tick();
      checks++; if (out_pc !== 32'h24) begin errors++; $display("FAIL redir_second: got %h want 24", out_pc); end
      drive(1'b1, 1'b1, 32'h40, 1'b1);
      tick();
      drive(1'b1, 1'b1, 32'h81, 1'b1);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (imem_addr !== 32'h80 || fifo_count !== 3'd0)
         begin errors++; $display("FAIL redir_b2b: got addr %h count %0d want 80 0", imem_addr, fifo_count); end
      tick();
      checks++; if (out_pc !== 32'h80) begin errors++; $display("FAIL redir_b2b_out: got %h want 80", out_pc); end
   endtask

   task automatic test_halt();
      int n;
      bit seen;
      imem[3] = HALT;
      do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      n = 0;
      while (halted !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got %b want 1 after %0d cycles", halted, n); end
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (out_valid && out_pc == 32'hC && out_instr == HALT) seen = 1'b1;
         tick();
      end
      checks++; if (!seen) begin errors++; $display("FAIL halt_word: got seen=0 want 1"); end
      checks++; if (imem_addr !== 32'h10 || halted !== 1'b1 || fifo_count !== 3'd0)
         begin errors++; $display("FAIL halt_hold: got addr %h h%b count %0d want 10 1 0", imem_addr, halted, fifo_count); end
      drive(1'b1, 1'b1, 32'h0, 1'b1);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (halted !== 1'b0 || imem_addr !== 32'h0)
         begin errors++; $display("FAIL halt_exit: got h%b addr %h want 0 0", halted, imem_addr); end
      tick();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL halt_resume: got %h want 4", imem_addr); end
      imem[3] = 32'h0000_0013;
   endtask

   task automatic test_fetch_en_drop();
      do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (5) tick();
      checks++; if (fifo_count !== 3'd4 || imem_addr !== 32'h10)
         begin errors++; $display("FAIL fe_fill: got count %0d addr %h want 4 10", fifo_count, imem_addr); end
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'(k * 4))
            begin errors++; $display("FAIL fe_drain k=%0d: got v%b pc %h want 1 %h", k, out_valid, out_pc, k * 4); end
         tick();
      end
      repeat (2) tick();
      checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h10)
         begin errors++; $display("FAIL fe_idle: got count %0d v%b addr %h want 0 0 10", fifo_count, out_valid, imem_addr); end
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || imem_addr !== 32'h14)
         begin errors++; $display("FAIL fe_resume: got v%b pc %h addr %h want 1 10 14", out_valid, out_pc, imem_addr); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (6) tick();
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL mid_pre: got count %0d want 4", fifo_count); end
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || imem_addr !== 32'h0)
         begin errors++; $display("FAIL mid_reset: got v%b count %0d addr %h want 0 0 0", out_valid, fifo_count, imem_addr); end
   endtask

   task automatic test_random();
      logic        fe, rv, rdy;
      logic [31:0] rpc;
      imem[10] = HALT;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         fe  = ($urandom % 8) != 0;
         rv  = ($urandom % 12) == 0;
         rdy = ($urandom % 3) != 0;
         rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom % 256);
         drive(fe, rv, rpc, rdy);
         checks++; if (out_valid !== ((q.size() != 0) && !rv))
            begin errors++; $display("FAIL rnd_valid k=%0d: got %b want %b", k, out_valid, (q.size() != 0) && !rv); end
         checks++; if (fifo_count !== 3'(q.size()))
            begin errors++; $display("FAIL rnd_count k=%0d: got %0d want %0d", k, fifo_count, q.size()); end
         checks++; if (out_pc !== m_head_pc() || out_instr !== m_head_ins())
            begin errors++; $display("FAIL rnd_head k=%0d: got %h/%h want %h/%h", k, out_pc, out_instr, m_head_pc(), m_head_ins()); end
         checks++; if (imem_addr !== m_pc)
            begin errors++; $display("FAIL rnd_addr k=%0d: got %h want %h", k, imem_addr, m_pc); end
         checks++; if (halted !== (m_st == 2))
            begin errors++; $display("FAIL rnd_halted k=%0d: got %b want %b", k, halted, m_st == 2); end
         tick();
      end
      imem[10] = 32'h0000_0013;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         imem[i] = $urandom;
         if (imem[i] == HALT) imem[i] = 32'h0000_0013;
      end
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_halt();
      test_fetch_en_drop();
      test_reset_mid_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
